// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame geometry and sizing helpers.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;
  localparam int unsigned SPI_DIV   = 4;
  localparam int unsigned SPI_GAP   = 2;
  localparam int unsigned SPI_DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_XFER_HI = 3'd2,
    ST_XFER_LO = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } spi_state_e;

  // Bits needed to hold the value max_val (never less than one).
  function automatic int unsigned spi_cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: tick_c marks the last clk of each sck half-period; sck is registered here.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned DIV = SPI_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sck_next,
  output logic tick_c,
  output logic sck
);

  localparam int unsigned       CW     = SPI_DIV_W;
  localparam logic [CW-1:0]     RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;

  // Depends only on the counter so the caller can qualify it without a combinational loop.
  assign tick_c = (cnt_q == '0);
  assign sck    = sck_q;

  // Count down while enabled; reload and apply the requested sck level at each half-period end.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en) begin
      cnt_d = RELOAD;
      sck_d = 1'b0;
    end else if (tick_c) begin
      cnt_d = RELOAD;
      sck_d = sck_next;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first byte transfer with ss framing and a post-frame ss-high gap.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter int unsigned DIV   = SPI_DIV,
  parameter int unsigned GAP   = SPI_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             ss,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned   BW         = spi_cnt_w(WIDTH);
  localparam int unsigned   GW         = spi_cnt_w(GAP);
  localparam logic [BW-1:0] BITS       = BW'(WIDTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             mosi_q, mosi_d;
  logic             ss_q, ss_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  logic div_en_c;
  logic sck_next_c;
  logic tick_c;
  logic rise_c;
  logic last_c;

  // Divider generates the half-period tick and owns the sck flop.
  spi_clk_div #(
    .DIV (DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en_c),
    .sck_next (sck_next_c),
    .tick_c   (tick_c),
    .sck      (sck)
  );

  // Next-state and output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    div_en_c   = 1'b0;
    sck_next_c = 1'b0;
    rise_c     = 1'b0;
    last_c     = (bit_cnt_q == BITS);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sh_d   = tx_data;
          mosi_d    = tx_data[WIDTH-1];
          bit_cnt_d = '0;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        div_en_c   = 1'b1;
        sck_next_c = 1'b1;
        rise_c     = tick_c;
      end
      ST_XFER_HI: begin
        div_en_c = 1'b1;
        if (tick_c) begin
          // Present the next bit on the falling edge; the last bit's value stays on mosi.
          if (bit_cnt_q < BITS) begin
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_d[WIDTH-1];
          end
          state_d = ST_XFER_LO;
        end
      end
      ST_XFER_LO: begin
        // After the final bit this is the trailing low half-period, so sck stays low.
        div_en_c   = 1'b1;
        sck_next_c = !last_c;
        if (tick_c) begin
          if (last_c) begin
            state_d = ST_HOLD;
          end else begin
            rise_c = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        div_en_c = 1'b1;
        if (tick_c) begin
          ss_d      = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          if (GAP == 0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_RELOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // sck rising edge: sample miso into the LSB and count the bit.
    if (rise_c) begin
      rx_sh_d   = (rx_sh_q << 1) | WIDTH'(miso);
      bit_cnt_d = bit_cnt_q + BW'(1);
      state_d   = ST_XFER_HI;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: four instances (DIV 4,1,2,7; GAP 2) behind one observation mux.
module tb_spi_master;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         lat;
    int         ss_low;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       miso;
  logic [7:0] tx_data;
  logic [1:0] sel;

  logic       start_a [4];
  logic       busy_a  [4];
  logic       done_a  [4];
  logic       ss_a    [4];
  logic       sck_a   [4];
  logic       mosi_a  [4];
  logic [7:0] rx_a    [4];

  logic       busy_m, done_m, ss_m, sck_m, mosi_m;
  logic [7:0] rx_m;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic       miso_tie;
  logic [7:0] slave_pre;
  logic       chk_gap;
  int         mon_rises = 0;
  int         n_frames  = 0;
  int         n_done    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign start_a[g] = start && (sel == 2'(g));
    spi_master #(
      .WIDTH (8),
      .DIV   ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 7),
      .GAP   (2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a[g]),
      .tx_data (tx_data),
      .busy    (busy_a[g]),
      .done    (done_a[g]),
      .rx_data (rx_a[g]),
      .ss      (ss_a[g]),
      .sck     (sck_a[g]),
      .mosi    (mosi_a[g]),
      .miso    (miso)
    );
  end

  assign busy_m = busy_a[sel];
  assign done_m = done_a[sel];
  assign ss_m   = ss_a[sel];
  assign sck_m  = sck_a[sel];
  assign mosi_m = mosi_a[sel];
  assign rx_m   = rx_a[sel];

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 1;
      2'd2:    return 2;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (busy_m !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_m !== val) begin
      checks++;
      errors++;
      $display("FAIL %s timeout busy=%b wanted %b", name, busy_m, val);
    end
  endtask

  task automatic run_frame(input logic [1:0] s, input logic [7:0] tx, input logic [7:0] pre,
                           input logic tie, input int lat, input int ss_low);
    exp_t e;
    @(negedge clk);
    sel       = s;
    miso_tie  = tie;
    slave_pre = pre;
    tx_data   = tx;
    e.tx      = tx;
    e.rx      = tie ? 8'hFF : pre;
    e.lat     = lat;
    e.ss_low  = ss_low;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(1'b0, 400, "frame_end");
    repeat (3) @(negedge clk);
  endtask

  // Monitor: mode-0 slave model, frame timing measurement and scoreboard compare on done.
  initial begin : monitor
    logic       ss_p, sck_p, mosi_p, have_prev;
    logic [7:0] slv_sh, slv_rx;
    int         idx, fall_idx, last_chg, last_rise, ss_low, gap_hi, dv;
    exp_t       e;
    ss_p = 1'b1; sck_p = 1'b0; mosi_p = 1'b0; have_prev = 1'b0;
    slv_sh = '0; slv_rx = '0; miso = 1'b0;
    idx = 0; fall_idx = 0; last_chg = 0; last_rise = 0; ss_low = 0; gap_hi = 0;
    forever begin
      @(posedge clk);
      #1;
      idx++;
      dv = div_of(sel);
      if (ss_p && !ss_m) begin
        if (chk_gap && have_prev) chk("ss_gap_cycles", 32'(gap_hi), 32'd3);
        have_prev = 1'b0;
        fall_idx  = idx;
        ss_low    = 0;
        mon_rises = 0;
        slv_sh    = slave_pre;
        slv_rx    = '0;
        last_chg  = idx;
        n_frames++;
      end
      if (!ss_p && ss_m) gap_hi = 0;
      if (ss_m) gap_hi++;
      else ss_low++;
      if (mosi_m !== mosi_p) begin
        chk("mosi_change_sck_low", 32'(sck_m), 32'd0);
        last_chg = idx;
      end
      if (sck_m && !sck_p) begin
        mon_rises++;
        checks++;
        if (idx - last_chg < dv) begin
          errors++;
          $display("FAIL mosi_setup actual=%0d cycles required>=%0d", idx - last_chg, dv);
        end
        if (mon_rises > 1) chk("sck_period", 32'(idx - last_rise), 32'(2 * dv));
        last_rise = idx;
        slv_rx = {slv_rx[6:0], mosi_m};
      end
      if (!sck_m && sck_p) slv_sh = slv_sh << 1;
      miso = miso_tie ? 1'b1 : slv_sh[7];
      if (done_m) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          chk("rx_data", 32'(rx_m), 32'(e.rx));
          chk("slave_rx", 32'(slv_rx), 32'(e.tx));
          chk("done_cycle", 32'(idx - fall_idx + 1), 32'(e.lat));
          chk("ss_low_cycles", 32'(ss_low), 32'(e.ss_low));
          chk("sck_rises", 32'(mon_rises), 32'd8);
          chk("ss_high_at_done", 32'(ss_m), 32'd1);
          n_done++;
          have_prev = 1'b1;
        end
      end
      ss_p = ss_m; sck_p = sck_m; mosi_p = mosi_m;
    end
  end

  // Stimulus: directed frames pushed to the scoreboard as they are issued.
  initial begin : stim
    logic [7:0] b2b [3];
    logic [7:0] rtx, rpre;
    int         n;
    exp_t       e;
    b2b[0] = 8'hC3; b2b[1] = 8'h5A; b2b[2] = 8'h0F;
    rst = 1'b1; start = 1'b0; tx_data = '0; sel = 2'd0;
    miso_tie = 1'b0; slave_pre = '0; chk_gap = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss", 32'(ss_m), 32'd1);
    chk("rst_sck", 32'(sck_m), 32'd0);
    chk("rst_mosi", 32'(mosi_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    chk("rst_rx", 32'(rx_m), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Abort after the 4th sck rise: immediate idle outputs, no done.
    slave_pre = 8'h3C; tx_data = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mon_rises < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_rise4", 32'(mon_rises), 32'd4);
    chk("abort_sck_before", 32'(sck_m), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ss", 32'(ss_m), 32'd1);
    chk("abort_sck", 32'(sck_m), 32'd0);
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_done", 32'(done_m), 32'd0);
    chk("abort_rx", 32'(rx_m), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_idle_busy", 32'(busy_m), 32'd0);

    // Loopback, DIV=4.
    run_frame(2'd0, 8'hA5, 8'h3C, 1'b0, 73, 72);
    // DIV=1, miso tied high.
    run_frame(2'd1, 8'h81, 8'h00, 1'b1, 19, 18);

    // Back-to-back with start held high; tx_data changes after each accept.
    @(negedge clk);
    sel = 2'd0; miso_tie = 1'b0; slave_pre = 8'h3C; tx_data = b2b[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.tx = b2b[k]; e.rx = 8'h3C; e.lat = 73; e.ss_low = 72;
      sb.push_back(e);
      wait_busy(1'b1, 20, "b2b_accept");
      chk_gap = 1'b1;
      tx_data = b2b[(k + 1) % 3];
      if (k == 2) start = 1'b0;
      wait_busy(1'b0, 400, "b2b_end");
    end
    chk_gap = 1'b0;
    repeat (5) @(negedge clk);

    // start pulsed mid-frame with tx_data=00 is ignored.
    @(negedge clk);
    sel = 2'd0; slave_pre = 8'h3C; tx_data = 8'h96;
    e.tx = 8'h96; e.rx = 8'h3C; e.lat = 73; e.ss_low = 72;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    tx_data = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_start_busy", 32'(busy_m), 32'd1);
    wait_busy(1'b0, 400, "mid_end");
    repeat (100) @(negedge clk);
    chk("mid_no_restart", 32'(busy_m), 32'd0);

    // Random bytes on DIV 1, 2, 7.
    for (int s = 1; s < 4; s++) begin
      for (int r = 0; r < 3; r++) begin
        rtx  = 8'($urandom_range(0, 255));
        rpre = 8'($urandom_range(0, 255));
        case (s)
          1:       run_frame(2'(s), rtx, rpre, 1'b0, 19, 18);
          2:       run_frame(2'(s), rtx, rpre, 1'b0, 37, 36);
          default: run_frame(2'(s), rtx, rpre, 1'b0, 127, 126);
        endcase
      end
    end

    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'd15);
    chk("frame_count", 32'(n_frames), 32'd16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
